// File: rtl/mem1_stage.sv
// mem1_stage: first memory stage. Registers the execute-stage outputs and
// checks load/store alignment. It issues one data-cache request per memory
// instruction and stalls upstream until that request is accepted. It passes
// results and exceptions on to memory2 and drives a forwarding request back
// to decode.
// Optional build macro MEM1_PERF_CNT_EN adds three load, store and wait-cycle
// performance counters.
// Handshake: a dcache request transfers on a cycle where dc_req_valid and
// dc_req_ready are both high. Once valid is raised, addr/wr/wstrb/wdata stay
// stable until that transfer. The only exception is flush_i, which withdraws
// valid in the same cycle.
module mem1_stage #(
  parameter logic [5:0] ECODE_ALE = 6'h09
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        stall_o,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ex_out,
  input  logic [31:0] in_rkd_data,
  input  logic [4:0]  in_rd,
  input  logic        in_is_wr_rd,
  input  logic        in_is_mem,
  input  logic        in_is_store,
  input  logic        in_is_signed,
  input  logic [1:0]  in_byte_type,
  input  logic        in_excp_valid,
  input  logic [5:0]  in_excp_ecode,
  output logic        dc_req_valid,
  input  logic        dc_req_ready,
  output logic [31:0] dc_req_addr,
  output logic        dc_req_wr,
  output logic [3:0]  dc_req_wstrb,
  output logic [31:0] dc_req_wdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_ex_out,
  output logic [4:0]  out_rd,
  output logic        out_is_wr_rd,
  output logic        out_is_mem,
  output logic        out_is_store,
  output logic        out_is_signed,
  output logic [1:0]  out_byte_type,
  output logic [1:0]  out_byte_off,
  output logic        out_excp_valid,
  output logic [5:0]  out_excp_ecode,
  output logic [31:0] out_excp_badv,
  output logic        fwd_valid,
  output logic [4:0]  fwd_idx,
  output logic [31:0] fwd_data,
  output logic        fwd_data_valid,
  output logic [1:0]  dbg_state_o
`ifdef MEM1_PERF_CNT_EN
  ,
  output logic [31:0] perf_ld_cnt,
  output logic [31:0] perf_st_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ISSUED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        valid_q, is_wr_rd_q, is_mem_q, is_store_q, is_signed_q, excp_q;
  logic [31:0] pc_q, ex_out_q, rkd_q;
  logic [4:0]  rd_q;
  logic [1:0]  byte_type_q;
  logic [5:0]  ecode_q;

  logic load_en, is_half, is_word, ale, mem_do, hs, mem_stall;

  // Stage register: captures execute outputs whenever the stage can advance or is flushed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      ex_out_q    <= '0;
      rkd_q       <= '0;
      rd_q        <= '0;
      is_wr_rd_q  <= 1'b0;
      is_mem_q    <= 1'b0;
      is_store_q  <= 1'b0;
      is_signed_q <= 1'b0;
      byte_type_q <= '0;
      excp_q      <= 1'b0;
      ecode_q     <= '0;
    end else if (load_en) begin
      valid_q     <= in_valid;
      pc_q        <= in_pc;
      ex_out_q    <= in_ex_out;
      rkd_q       <= in_rkd_data;
      rd_q        <= in_rd;
      is_wr_rd_q  <= in_is_wr_rd;
      is_mem_q    <= in_is_mem;
      is_store_q  <= in_is_store;
      is_signed_q <= in_is_signed;
      byte_type_q <= in_byte_type;
      excp_q      <= in_excp_valid;
      ecode_q     <= in_excp_ecode;
    end
  end

  // Alignment, request gating and stall generation.
  always_comb begin
    is_half      = (byte_type_q == 2'd1);
    is_word      = byte_type_q[1];  // type 3 is reserved and treated as word
    ale          = valid_q & is_mem_q & ~excp_q &
                   ((is_half & ex_out_q[0]) | (is_word & (ex_out_q[1:0] != 2'b00)));
    mem_do       = valid_q & is_mem_q & ~excp_q & ~ale;
    dc_req_valid = mem_do & ~flush_i & (state_q != S_ISSUED);
    hs           = dc_req_valid & dc_req_ready;
    mem_stall    = mem_do & (state_q != S_ISSUED) & ~hs;
    stall_o      = stall_i | mem_stall;
    load_en      = ~stall_o | flush_i;
    out_valid    = valid_q & ~stall_o & ~flush_i;
  end

  // Request payload: byte enables are shifted by the address offset, and write data is replicated across lanes.
  always_comb begin
    dc_req_addr  = ex_out_q;
    dc_req_wr    = is_store_q;
    dc_req_wstrb = 4'b0000;
    dc_req_wdata = rkd_q;
    if (valid_q & is_mem_q) begin
      unique case (byte_type_q)
        2'd0:    dc_req_wstrb = 4'b0001 << ex_out_q[1:0];
        2'd1:    dc_req_wstrb = 4'b0011 << ex_out_q[1:0];
        default: dc_req_wstrb = 4'b1111;
      endcase
    end
    unique case (byte_type_q)
      2'd0:    dc_req_wdata = {4{rkd_q[7:0]}};
      2'd1:    dc_req_wdata = {2{rkd_q[15:0]}};
      default: dc_req_wdata = rkd_q;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: ISSUED blocks a second request while downstream still holds the instruction.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (mem_do) begin
            if (dc_req_ready) state_d = stall_i ? S_ISSUED : S_IDLE;
            else              state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (!mem_do)           state_d = S_IDLE;
          else if (dc_req_ready) state_d = stall_i ? S_ISSUED : S_IDLE;
        end
        S_ISSUED: begin
          if (!stall_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign dbg_state_o = state_q;

  // Pass-through, exception and forwarding outputs.
  always_comb begin
    out_pc         = pc_q;
    out_ex_out     = ex_out_q;
    out_rd         = rd_q;
    out_is_wr_rd   = is_wr_rd_q;
    out_is_mem     = is_mem_q;
    out_is_store   = is_store_q;
    out_is_signed  = is_signed_q;
    out_byte_type  = byte_type_q;
    out_byte_off   = ex_out_q[1:0];
    out_excp_valid = (excp_q | ale) & out_valid;
    // An earlier-stage exception takes priority over a misaligned access.
    out_excp_ecode = out_excp_valid ? (excp_q ? ecode_q : ECODE_ALE) : 6'h00;
    out_excp_badv  = ale ? ex_out_q : 32'h0;
    fwd_valid      = valid_q & is_wr_rd_q & (rd_q != 5'd0) & ~excp_q & ~ale;
    fwd_idx        = rd_q;
    fwd_data       = ex_out_q;
    // Load data has not returned yet, so only non-load results can be forwarded.
    fwd_data_valid = valid_q & ~(is_mem_q & ~is_store_q);
  end

`ifdef MEM1_PERF_CNT_EN
  // Wrapping counters for load and store handshakes and for cycles spent waiting on the cache.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_ld_cnt   <= '0;
      perf_st_cnt   <= '0;
      perf_wait_cnt <= '0;
    end else begin
      if (hs & ~is_store_q)     perf_ld_cnt   <= perf_ld_cnt + 32'd1;
      if (hs & is_store_q)      perf_st_cnt   <= perf_st_cnt + 32'd1;
      if (state_q == S_WAIT)    perf_wait_cnt <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: directed bench for mem1_stage. It covers aligned, misaligned and
// sub-word accesses, a slow cache, a downstream stall after handshake, and a flush.
module tb_mem1_stage;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ISSUED = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n, flush_i, stall_i, stall_o;
  logic        in_valid, in_is_wr_rd, in_is_mem, in_is_store, in_is_signed, in_excp_valid;
  logic [31:0] in_pc, in_ex_out, in_rkd_data;
  logic [4:0]  in_rd;
  logic [1:0]  in_byte_type;
  logic [5:0]  in_excp_ecode;
  logic        dc_req_valid, dc_req_ready, dc_req_wr;
  logic [31:0] dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_wstrb;
  logic        out_valid, out_is_wr_rd, out_is_mem, out_is_store, out_is_signed, out_excp_valid;
  logic [31:0] out_pc, out_ex_out, out_excp_badv, fwd_data;
  logic [4:0]  out_rd, fwd_idx;
  logic [1:0]  out_byte_type, out_byte_off, dbg_state_o;
  logic [5:0]  out_excp_ecode;
  logic        fwd_valid, fwd_data_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;
  int hs_mark;
  logic [31:0] exp_q[$];

  mem1_stage dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .stall_i(stall_i), .stall_o(stall_o),
    .in_valid(in_valid), .in_pc(in_pc), .in_ex_out(in_ex_out), .in_rkd_data(in_rkd_data),
    .in_rd(in_rd), .in_is_wr_rd(in_is_wr_rd), .in_is_mem(in_is_mem), .in_is_store(in_is_store),
    .in_is_signed(in_is_signed), .in_byte_type(in_byte_type), .in_excp_valid(in_excp_valid),
    .in_excp_ecode(in_excp_ecode), .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_wr(dc_req_wr), .dc_req_wstrb(dc_req_wstrb),
    .dc_req_wdata(dc_req_wdata), .out_valid(out_valid), .out_pc(out_pc), .out_ex_out(out_ex_out),
    .out_rd(out_rd), .out_is_wr_rd(out_is_wr_rd), .out_is_mem(out_is_mem),
    .out_is_store(out_is_store), .out_is_signed(out_is_signed), .out_byte_type(out_byte_type),
    .out_byte_off(out_byte_off), .out_excp_valid(out_excp_valid), .out_excp_ecode(out_excp_ecode),
    .out_excp_badv(out_excp_badv), .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data(fwd_data),
    .fwd_data_valid(fwd_data_valid), .dbg_state_o(dbg_state_o)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] rd, input logic wr_rd, input logic is_mem,
                       input logic is_store, input logic [1:0] bt,
                       input logic ev, input logic [5:0] ec);
    in_valid = 1'b1; in_pc = pc; in_ex_out = addr; in_rkd_data = data; in_rd = rd;
    in_is_wr_rd = wr_rd; in_is_mem = is_mem; in_is_store = is_store; in_is_signed = 1'b0;
    in_byte_type = bt; in_excp_valid = ev; in_excp_ecode = ec;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_pc = '0; in_ex_out = '0; in_rkd_data = '0; in_rd = '0;
    in_is_wr_rd = 1'b0; in_is_mem = 1'b0; in_is_store = 1'b0; in_is_signed = 1'b0;
    in_byte_type = '0; in_excp_valid = 1'b0; in_excp_ecode = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: counts handshakes and checks retiring PCs in order, sampled mid-cycle once inputs are stable.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (dc_req_valid && dc_req_ready) hs_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else check("out_pc", out_pc, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0; dc_req_ready = 1'b1;
    idle_in();
    repeat (3) @(posedge clk);
    tick(); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_dc_req_valid", dc_req_valid, 0);
    check("rst_stall_o", stall_o, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_data_valid", fwd_data_valid, 0);
    check("rst_ecode", out_excp_ecode, 0);
    check("rst_wstrb", dc_req_wstrb, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_state", dbg_state_o, ST_IDLE);
    rst_n = 1'b1;

    // Aligned word load.
    tick(); drive(32'h100, 32'h1000, 32'h0, 5'd5, 1, 1, 0, 2'd2, 0, 6'h0); exp_q.push_back(32'h100);
    tick(); idle_in(); #1;
    check("wl_req_valid", dc_req_valid, 1);
    check("wl_wstrb", dc_req_wstrb, 4'hF);
    check("wl_addr", dc_req_addr, 32'h1000);
    check("wl_wr", dc_req_wr, 0);
    check("wl_stall_o", stall_o, 0);
    check("wl_out_valid", out_valid, 1);
    check("wl_fwd_valid", fwd_valid, 1);
    check("wl_fwd_idx", fwd_idx, 5);
    check("wl_fwd_data_valid", fwd_data_valid, 0);

    // Misaligned half load.
    tick(); drive(32'h104, 32'h1001, 32'h0, 5'd6, 1, 1, 0, 2'd1, 0, 6'h0); exp_q.push_back(32'h104);
    tick(); idle_in(); #1;
    check("ale_req_valid", dc_req_valid, 0);
    check("ale_out_valid", out_valid, 1);
    check("ale_excp_valid", out_excp_valid, 1);
    check("ale_ecode", out_excp_ecode, 6'h09);
    check("ale_badv", out_excp_badv, 32'h1001);
    check("ale_fwd_valid", fwd_valid, 0);
    check("ale_stall_o", stall_o, 0);

    // Byte store to the top byte lane.
    tick(); drive(32'h108, 32'h2003, 32'h12345678, 5'd0, 0, 1, 1, 2'd0, 0, 6'h0); exp_q.push_back(32'h108);
    tick(); idle_in(); #1;
    check("bs_req_valid", dc_req_valid, 1);
    check("bs_wstrb", dc_req_wstrb, 4'b1000);
    check("bs_wdata", dc_req_wdata, 32'h78787878);
    check("bs_wr", dc_req_wr, 1);
    check("bs_byte_off", out_byte_off, 2'd3);
    check("bs_excp_valid", out_excp_valid, 0);

    // Half store to the upper half.
    tick(); drive(32'h10C, 32'h2002, 32'hAABBCCDD, 5'd0, 0, 1, 1, 2'd1, 0, 6'h0); exp_q.push_back(32'h10C);
    tick(); idle_in(); #1;
    check("hs_wstrb", dc_req_wstrb, 4'b1100);
    check("hs_wdata", dc_req_wdata, 32'hCCDDCCDD);
    check("hs_excp_valid", out_excp_valid, 0);

    // An earlier exception outranks a misaligned word address.
    tick(); drive(32'h110, 32'h0003, 32'h0, 5'd3, 1, 1, 0, 2'd2, 1, 6'h0A); exp_q.push_back(32'h110);
    tick(); idle_in(); #1;
    check("ex_req_valid", dc_req_valid, 0);
    check("ex_excp_valid", out_excp_valid, 1);
    check("ex_ecode", out_excp_ecode, 6'h0A);
    check("ex_badv", out_excp_badv, 0);
    check("ex_fwd_valid", fwd_valid, 0);

    // Cache not ready for three cycles.
    tick(); drive(32'h120, 32'h4000, 32'h0, 5'd8, 1, 1, 0, 2'd2, 0, 6'h0); exp_q.push_back(32'h120);
    dc_req_ready = 1'b0;
    hs_mark = hs_cnt;
    tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      check("wt_stall_o", stall_o, 1);
      check("wt_req_valid", dc_req_valid, 1);
      check("wt_addr", dc_req_addr, 32'h4000);
      check("wt_out_valid", out_valid, 0);
      check("wt_state", dbg_state_o, (i == 0) ? ST_IDLE : ST_WAIT);
    end
    tick(); dc_req_ready = 1'b1; #1;
    check("wt_rel_req_valid", dc_req_valid, 1);
    check("wt_rel_stall_o", stall_o, 0);
    check("wt_rel_out_valid", out_valid, 1);
    check("wt_rel_state", dbg_state_o, ST_WAIT);
    tick(); #1;
    check("wt_end_state", dbg_state_o, ST_IDLE);
    check("wt_handshakes", hs_cnt - hs_mark, 1);

    // Handshake while downstream is stalled.
    tick(); drive(32'h130, 32'h5000, 32'hCAFEF00D, 5'd0, 0, 1, 1, 2'd2, 0, 6'h0); exp_q.push_back(32'h130);
    hs_mark = hs_cnt;
    tick(); idle_in(); stall_i = 1'b1; #1;
    check("is_req_valid", dc_req_valid, 1);
    check("is_wdata", dc_req_wdata, 32'hCAFEF00D);
    check("is_stall_o", stall_o, 1);
    check("is_out_valid", out_valid, 0);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      check("is_held_req_valid", dc_req_valid, 0);
      check("is_held_state", dbg_state_o, ST_ISSUED);
      check("is_held_stall_o", stall_o, 1);
    end
    tick(); stall_i = 1'b0; #1;
    check("is_rel_out_valid", out_valid, 1);
    check("is_rel_req_valid", dc_req_valid, 0);
    check("is_rel_stall_o", stall_o, 0);
    tick(); #1;
    check("is_end_state", dbg_state_o, ST_IDLE);
    check("is_handshakes", hs_cnt - hs_mark, 1);

    // Flush while waiting for the cache; the instruction presented during the flush is captured.
    tick(); drive(32'h140, 32'h6000, 32'h0, 5'd9, 1, 1, 0, 2'd2, 0, 6'h0);
    dc_req_ready = 1'b0;
    tick(); idle_in(); #1;
    check("fl_pre_req_valid", dc_req_valid, 1);
    tick(); flush_i = 1'b1;
    drive(32'h144, 32'h77, 32'h0, 5'd7, 1, 0, 0, 2'd2, 0, 6'h0); exp_q.push_back(32'h144);
    #1;
    check("fl_state", dbg_state_o, ST_WAIT);
    check("fl_req_valid", dc_req_valid, 0);
    check("fl_out_valid", out_valid, 0);
    tick(); flush_i = 1'b0; idle_in(); dc_req_ready = 1'b1; #1;
    check("fl_post_state", dbg_state_o, ST_IDLE);
    check("fl_post_out_valid", out_valid, 1);
    check("fl_post_req_valid", dc_req_valid, 0);
    check("fl_post_fwd_valid", fwd_valid, 1);
    check("fl_post_fwd_data", fwd_data, 32'h77);
    check("fl_post_fwd_data_valid", fwd_data_valid, 1);

    repeat (3) tick();
    #5;
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem1_stage.md
Name: mem1_stage

Overview:
- First memory stage, directly downstream of the execute stage; consumes its per-instruction outputs.
- Registers the incoming instruction and checks load/store address alignment (raises ALE).
- Issues exactly one data-cache request per memory instruction over a valid/ready handshake and stalls the pipeline until the request is accepted.
- Passes results and exception state on to the second memory stage and drives a forwarding request back to decode.

Parameters:
- ECODE_ALE, 6'h09, exception code reported for a misaligned access.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush_i  in  1  pipeline flush
- stall_i  in  1  stall from downstream
- stall_o  out  1  stall to upstream
- in_valid  in  1  instruction valid from execute
- in_pc  in  32  instruction PC
- in_ex_out  in  32  ALU result / effective address
- in_rkd_data  in  32  store data
- in_rd  in  5  destination register
- in_is_wr_rd  in  1  writes rd
- in_is_mem  in  1  load/store
- in_is_store  in  1  store (valid with is_mem)
- in_is_signed  in  1  sign-extend load
- in_byte_type  in  2  0 byte, 1 half, 2 word (3 reserved, treat as word)
- in_excp_valid  in  1  earlier-stage exception
- in_excp_ecode  in  6  earlier-stage ecode
- dc_req_valid  out  1  dcache request
- dc_req_ready  in  1  dcache accepts
- dc_req_addr  out  32  byte address
- dc_req_wr  out  1  store
- dc_req_wstrb  out  4  byte enables
- dc_req_wdata  out  32  store data, lane-replicated
- out_valid  out  1  to memory2
- out_pc, out_ex_out  out  32  passed through
- out_rd  out  5, out_is_wr_rd  out  1, out_is_mem  out  1, out_is_store  out  1, out_is_signed  out  1, out_byte_type  out  2, out_byte_off  out  2 (= addr[1:0])
- out_excp_valid  out  1, out_excp_ecode  out  6, out_excp_badv  out  32
- fwd_valid  out  1, fwd_idx  out  5, fwd_data  out  32, fwd_data_valid  out  1

Behaviour:
- Input register
  - On reset: valid_r=0, excp_r=0.
  - Otherwise loads all in_* when (~stall_o | flush_i).
- Alignment
  - ale = valid_r & is_mem_r & ~excp_r & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - Byte access never misaligned.
- mem_do = valid_r & is_mem_r & ~excp_r & ~ale. No request on exception or ALE.
- FSM (reset IDLE)
  - IDLE: if mem_do & ~flush_i and handshake (dc_req_valid & dc_req_ready) fires: go to ISSUED if stall_i, else stay IDLE. If mem_do & ~flush_i & ~dc_req_ready: go to WAIT.
  - WAIT: dc_req_valid held high, addr/wr/wstrb/wdata stable. On ready: go to ISSUED if stall_i, else IDLE.
  - ISSUED: no further request. Go to IDLE when ~stall_i.
  - flush_i in any state: go to IDLE next cycle and deassert dc_req_valid the same cycle. The dcache tolerates request withdrawal on flush.
- Request outputs
  - dc_req_valid = mem_do & ~flush_i & state!=ISSUED.
  - dc_req_wstrb:
    - byte: 4'b0001<<off
    - half: 4'b0011<<off
    - word: 4'b1111
    - loads drive the same mask.
  - dc_req_wdata:
    - byte: {4{d[7:0]}}
    - half: {2{d[15:0]}}
    - word: d
- Stall and valid
  - mem_stall = mem_do & state!=ISSUED & ~(dc_req_valid & dc_req_ready).
  - stall_o = stall_i | mem_stall.
  - out_valid = valid_r & ~stall_o & ~flush_i. Combinational, so latency is 1 cycle through the stage when unstalled.
- Exceptions
  - out_excp_valid = (excp_r | ale) & out_valid.
  - ecode = excp_r ? stored ecode : ECODE_ALE. An earlier exception has priority over ALE.
  - badv = ex_out_r on ALE, else 0.
- Forwarding
  - fwd_valid = valid_r & is_wr_rd_r & rd_r!=0 & ~excp_r & ~ale.
  - fwd_data = ex_out_r.
  - fwd_data_valid = ~(is_mem_r & ~is_store_r). Load data is not yet available.
- Reset values: every output is 0 during and after reset until a valid instruction is captured.

Optional Feature:
- Macro: MEM1_PERF_CNT_EN.
- With it defined, three 32-bit wrapping counters are added and exposed on output ports perf_ld_cnt, perf_st_cnt, perf_wait_cnt:
  - load handshakes
  - store handshakes
  - cycles with state==WAIT
- Counters clear on reset and are not affected by flush.
- Without it, the ports and counters are absent.

Test Plan:
- Aligned word load addr 0x1000, dc_req_ready=1 -> one cycle dc_req_valid, wstrb 4'hF, no stall, out_valid next edge, fwd_data_valid=0.
- Half load addr 0x1001 -> no dc_req_valid, out_excp_valid=1, ecode 0x09, badv 0x1001, fwd_valid=0.
- Byte store addr 0x2003, data 0x12345678 -> wstrb 4'b1000, wdata 0x78787878, dc_req_wr=1.
- dc_req_ready low 3 cycles -> stall_o high 3 cycles, addr stable, exactly one handshake, state WAIT->IDLE.
- Handshake while stall_i=1 for 2 more cycles -> state ISSUED, dc_req_valid=0 during those cycles, no second request.
- flush_i in WAIT -> dc_req_valid drops same cycle, FSM to IDLE, out_valid=0, next instruction captured.
